// File: rtl/pbit_pkg.sv
// Shared fixed-point definitions for the p-bit datapath: s[3][2] format
// constants, the MAC sequencing states and the clamping helper that the
// activation stage also uses.
package pbit_pkg;

    localparam int FRAC_BITS = 2;
    localparam int IN_MIN    = -32;
    localparam int IN_MAX    = 31;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    // Clamp a signed value into the range of a two's complement word of
    // the given width; never wraps.
    function automatic int saturate(input int value, input int width);
        int lo;
        int hi;
        lo = -(1 << (width - 1));
        hi = (1 << (width - 1)) - 1;
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage

// File: rtl/pbit_mac.sv
// Serial multiply-accumulate producing the saturated input current I_i of a
// p-bit. Neighbour spins are latched on start; one static weight is added or
// subtracted per cycle on top of the bias, then the sum is clamped to s[3][2].
module pbit_mac
    import pbit_pkg::*;
#(
    parameter int N_NEIGHBORS      = 4,
    parameter int WEIGHT_PRECISION = 6,
    parameter logic [N_NEIGHBORS*WEIGHT_PRECISION-1:0] W = {4{6'sd4}},
    parameter logic signed [WEIGHT_PRECISION-1:0] H = 6'sd0,
    parameter int OUT_WIDTH        = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [N_NEIGHBORS-1:0]      p_in,
    output logic                        busy,
    output logic                        done,
    output logic [OUT_WIDTH-1:0]        I_out
);

    // Wide enough for the bias plus N full-scale terms, so no overflow.
    localparam int ACC_W = WEIGHT_PRECISION + $clog2(N_NEIGHBORS + 1) + 1;
    localparam int IDX_W = (N_NEIGHBORS > 1) ? $clog2(N_NEIGHBORS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEIGHBORS - 1);

    state_t                       state_reg;
    logic [N_NEIGHBORS-1:0]       p_lat_reg;
    logic signed [ACC_W-1:0]      acc_reg;
    logic [IDX_W-1:0]             idx_reg;
    logic                         busy_reg;
    logic                         done_reg;
    logic [OUT_WIDTH-1:0]         i_out_reg;

    logic signed [WEIGHT_PRECISION-1:0] w_k;
    logic signed [ACC_W-1:0]      w_ext;
    logic signed [ACC_W-1:0]      h_ext;
    logic signed [ACC_W-1:0]      acc_next;
    int                           sat_full;

    // Select the current weight and form acc +/- W[idx] depending on the spin.
    always_comb begin
        w_k      = W[int'(idx_reg)*WEIGHT_PRECISION +: WEIGHT_PRECISION];
        w_ext    = ACC_W'(w_k);
        h_ext    = ACC_W'(H);
        acc_next = p_lat_reg[idx_reg] ? (acc_reg + w_ext) : (acc_reg - w_ext);
        sat_full = saturate(int'(acc_reg), OUT_WIDTH);
    end

    // Sequencer: latch on start, accumulate one term per cycle, publish result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            p_lat_reg <= '0;
            acc_reg   <= '0;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            i_out_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        p_lat_reg <= p_in;
                        acc_reg   <= h_ext;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_reg <= acc_next;
                    idx_reg <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX)
                        state_reg <= OUTPUT;
                end
                OUTPUT: begin
                    i_out_reg <= sat_full[OUT_WIDTH-1:0];
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_reg;
    assign done  = done_reg;
    assign I_out = i_out_reg;

endmodule

// File: tb/tb_pbit_mac.sv
// Self-checking bench for pbit_mac: four instances with different weight and
// bias sets share one stimulus stream and are compared against a plain
// arithmetic model of sat(H + sum(+/-W[k])).
module tb_pbit_mac;

    localparam int NI = 4;

    localparam logic [23:0] WS [NI] = '{
        {4{6'sd4}},
        {4{6'sd31}},
        {4{6'sd31}},
        {-6'sd32, 6'sd31, -6'sd3, 6'sd7}
    };
    localparam logic signed [5:0] HS [NI] = '{6'sd0, 6'sd31, -6'sd32, -6'sd5};

    // Reference weights as plain integers, indexed [instance][neighbour].
    int wt [NI][4] = '{
        '{4, 4, 4, 4},
        '{31, 31, 31, 31},
        '{31, 31, 31, 31},
        '{7, -3, 31, -32}
    };
    int hb [NI] = '{0, 31, -32, -5};

    logic              clk;
    logic              reset;
    logic              start;
    logic [3:0]        p_in;
    logic [NI-1:0]     busy_v;
    logic [NI-1:0]     done_v;
    logic signed [5:0] iout [NI];

    int n_cmp;
    int n_err;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            pbit_mac #(
                .N_NEIGHBORS(4),
                .WEIGHT_PRECISION(6),
                .W(WS[gi]),
                .H(HS[gi]),
                .OUT_WIDTH(6)
            ) dut (
                .clk(clk),
                .reset(reset),
                .start(start),
                .p_in(p_in),
                .busy(busy_v[gi]),
                .done(done_v[gi]),
                .I_out(iout[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model(input int inst, input logic [3:0] p);
        int s;
        s = hb[inst];
        for (int k = 0; k < 4; k++)
            s += p[k] ? wt[inst][k] : -wt[inst][k];
        if (s > 31) s = 31;
        if (s < -32) s = -32;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [3:0] p);
        p_in  = p;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called right after the start edge; returns positioned in the done cycle.
    task automatic wait_done(input string name, input logic [3:0] p);
        int cycles;
        cycles = 0;
        while (done_v[0] !== 1'b1 && cycles < 12) begin
            n_cmp++;
            if (busy_v !== 4'hF || done_v !== 4'h0) begin
                n_err++;
                $display("FAIL %s busy/done during op: busy=%b done=%b required busy=1111 done=0000",
                         name, busy_v, done_v);
            end
            tick();
            cycles++;
        end
        n_cmp++;
        if (cycles !== 5) begin
            n_err++;
            $display("FAIL %s latency: got %0d required 5", name, cycles);
        end
        n_cmp++;
        if (done_v !== 4'hF || busy_v !== 4'h0) begin
            n_err++;
            $display("FAIL %s done cycle: done=%b busy=%b required done=1111 busy=0000",
                     name, done_v, busy_v);
        end
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (int'(iout[i]) !== model(i, p)) begin
                n_err++;
                $display("FAIL %s I_out[%0d] p=%b: got %0d required %0d",
                         name, i, p, int'(iout[i]), model(i, p));
            end
        end
        $display("op %s p_in=%b I_out=%0d/%0d/%0d/%0d", name, p,
                 int'(iout[0]), int'(iout[1]), int'(iout[2]), int'(iout[3]));
    endtask

    task automatic run_op(input string name, input logic [3:0] p);
        start_op(p);
        wait_done(name, p);
        tick();
        n_cmp++;
        if (done_v !== 4'h0) begin
            n_err++;
            $display("FAIL %s done width: done=%b required 0000 one cycle after pulse", name, done_v);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        p_in  = 4'h0;
        tick();
        tick();
        n_cmp++;
        if (busy_v !== 4'h0 || done_v !== 4'h0) begin
            n_err++;
            $display("FAIL reset busy/done: busy=%b done=%b required 0000/0000", busy_v, done_v);
        end
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (iout[i] !== 6'sd0) begin
                n_err++;
                $display("FAIL reset I_out[%0d]: got %0d required 0", i, int'(iout[i]));
            end
        end
        reset = 1'b1;
        tick();
        $display("reset done busy=%b done=%b", busy_v, done_v);
    endtask

    task automatic test_directed();
        run_op("all_up", 4'b1111);
        n_cmp++;
        if (iout[0] !== 6'sd16 || iout[1] !== 6'sd31) begin
            n_err++;
            $display("FAIL all_up const: got %0d,%0d required 16,31", int'(iout[0]), int'(iout[1]));
        end
        run_op("all_down", 4'b0000);
        n_cmp++;
        if (iout[0] !== 6'b110000 || iout[2] !== -6'sd32) begin
            n_err++;
            $display("FAIL all_down const: got %0d,%0d required -16,-32", int'(iout[0]), int'(iout[2]));
        end
        run_op("mixed", 4'b0101);
        n_cmp++;
        if (iout[0] !== 6'sd0) begin
            n_err++;
            $display("FAIL mixed const: got %0d required 0", int'(iout[0]));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++)
            run_op("random", 4'($urandom_range(0, 15)));
    endtask

    task automatic test_busy_ignore();
        logic [3:0] p0;
        int dones;
        int got;
        p0 = 4'b0011;
        start_op(p0);
        tick();
        p_in  = ~p0;
        start = 1'b1;
        tick();
        start = 1'b0;
        p_in  = 4'($urandom_range(0, 15));
        dones = 0;
        got   = -999;
        for (int c = 0; c < 12; c++) begin
            if (done_v[0] === 1'b1) begin
                dones++;
                got = int'(iout[3]);
            end
            tick();
        end
        n_cmp++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL busy_ignore done count: got %0d required 1", dones);
        end
        n_cmp++;
        if (got !== model(3, p0)) begin
            n_err++;
            $display("FAIL busy_ignore I_out: got %0d required %0d", got, model(3, p0));
        end
        $display("op busy_ignore p_in=%b dones=%0d I_out[3]=%0d", p0, dones, got);
    endtask

    task automatic test_back_to_back();
        start_op(4'b1110);
        wait_done("b2b_first", 4'b1110);
        start_op(4'b1001);
        wait_done("b2b_second", 4'b1001);
        tick();
    endtask

    task automatic test_reset_abort();
        int dones;
        run_op("pre_abort", 4'b1111);
        start_op(4'b1010);
        tick();
        reset = 1'b0;
        tick();
        n_cmp++;
        if (busy_v !== 4'h0 || done_v !== 4'h0) begin
            n_err++;
            $display("FAIL abort busy/done: busy=%b done=%b required 0000/0000", busy_v, done_v);
        end
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (iout[i] !== 6'sd0) begin
                n_err++;
                $display("FAIL abort I_out[%0d]: got %0d required 0", i, int'(iout[i]));
            end
        end
        reset = 1'b1;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done_v !== 4'h0) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_err++;
            $display("FAIL abort spurious done: got %0d pulses required 0", dones);
        end
        $display("op abort spurious_dones=%0d", dones);
        run_op("post_abort", 4'b0110);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        start = 1'b0;
        p_in  = 4'h0;
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
